// File: rtl/mem_bank_xlate.sv
// Registered CPU-to-physical address translator with EB/FB/SB bank registers.
// Optional BANK_SHADOW_EN adds a one-deep bank shadow for interrupt entry/exit.
module mem_bank_xlate #(
  parameter int EBANK_W    = 3,
  parameter int FBANK_W    = 5,
  parameter int SBANK_W    = 1,
  parameter int NUM_FBANKS = 36,
  parameter int PHYS_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [1:0]         wr_sel,
  input  logic [15:0]        wr_data,
  input  logic               irq_enter,
  input  logic               irq_exit,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [11:0]        req_addr,
  input  logic               req_write,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [PHYS_W-1:0]  resp_addr,
  output logic               resp_fault,
  output logic [EBANK_W-1:0] eb_q,
  output logic [FBANK_W-1:0] fb_q,
  output logic [SBANK_W-1:0] sb_q
);

  // Wide enough for the largest effective fixed bank (FB plus 8*SB).
  localparam int BANK_W = $clog2((2**FBANK_W) + 8 * ((2**SBANK_W) - 1));

  localparam logic [1:0] SEL_EB = 2'd0;
  localparam logic [1:0] SEL_FB = 2'd1;
  localparam logic [1:0] SEL_BB = 2'd2;
  localparam logic [1:0] SEL_SB = 2'd3;

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // a response leaves on any rising edge where resp_valid && resp_ready, and
  // resp_addr/resp_fault stay frozen while resp_valid && !resp_ready.
  logic accept;
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  // Bank registers
`ifdef BANK_SHADOW_EN
  logic [EBANK_W-1:0] eb_sh;
  logic [FBANK_W-1:0] fb_sh;
  logic [SBANK_W-1:0] sb_sh;

  // Shadow always captures the values from before this edge's restore or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eb_sh <= '0;
      fb_sh <= '0;
      sb_sh <= '0;
    end else if (irq_enter) begin
      eb_sh <= eb_q;
      fb_sh <= fb_q;
      sb_sh <= sb_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eb_q <= '0;
      fb_q <= '0;
      sb_q <= '0;
`ifdef BANK_SHADOW_EN
    end else if (irq_exit) begin
      eb_q <= eb_sh;
      fb_q <= fb_sh;
      sb_q <= sb_sh;
`endif
    end else if (wr_en) begin
      case (wr_sel)
        SEL_EB: eb_q <= wr_data[EBANK_W-1:0];
        SEL_FB: fb_q <= wr_data[FBANK_W-1:0];
        SEL_BB: begin
          fb_q <= wr_data[FBANK_W+EBANK_W-1:EBANK_W];
          eb_q <= wr_data[EBANK_W-1:0];
        end
        SEL_SB: sb_q <= wr_data[SBANK_W-1:0];
        default: ;
      endcase
    end
  end

  // Upper wr_data bits and (in the plain build) the irq strobes have no effect.
  logic unused_bits;
  assign unused_bits = ^{wr_data, irq_enter, irq_exit};

  // Address decode
  logic              sb_active;
  logic [BANK_W-1:0] fbank;
  logic              in_fixed;
  logic              in_sw_fixed;
  logic              fault_next;
  logic [PHYS_W-1:0] phys_next;

  assign sb_active   = (fb_q[FBANK_W-1 -: 2] == 2'b11);
  assign fbank       = BANK_W'(fb_q) + (sb_active ? (BANK_W'(sb_q) << 3) : '0);
  assign in_sw_fixed = (req_addr[11:10] == 2'b01);
  assign in_fixed    = req_addr[11] || in_sw_fixed;

  always_comb begin
    phys_next  = '0;
    fault_next = 1'b0;
    if (req_addr[11]) begin
      phys_next = PHYS_W'(req_addr);
    end else if (in_sw_fixed) begin
      phys_next = PHYS_W'({fbank, req_addr[9:0]});
    end else if (req_addr[9:8] == 2'b11) begin
      phys_next = PHYS_W'({eb_q, req_addr[7:0]});
    end else begin
      phys_next = PHYS_W'(req_addr);
    end
    if ((req_write && in_fixed) || (in_sw_fixed && (int'(fbank) >= NUM_FBANKS))) begin
      fault_next = 1'b1;
    end
    if (fault_next) begin
      phys_next = '0;
    end
  end

  // Single output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_fault <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_addr  <= phys_next;
      resp_fault <= fault_next;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
